// File: rtl/fifo_rd_streamer_if.sv
// Handshake bundle for the FIFO read-side streamer.
// It carries the FIFO pop/empty/data side and the consumer valid/ready/data side.
// The master modport is the streamer. The slave modport is the FIFO plus consumer environment.
`timescale 1ns/1ps
interface fifo_rd_streamer_if #(
    parameter int DW = 32
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_pop;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_pop,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_pop,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side drain engine for the async FIFO (rdclk domain).
// Pops the FIFO while it is non-empty. A 2-entry skid (head/tail) absorbs the
// 1-cycle FIFO read latency, and words are presented on a valid/ready stream.
// Optional feature: define FIFO_RD_CNT_EN to build the 16-bit delivered-word
// counter on rd_count. Without it, rd_count is tied to zero.
`timescale 1ns/1ps
module fifo_rd_streamer #(
    parameter int DW   = 32,
    parameter int SKID = 2
) (
    input  logic                 rdclk,
    input  logic                 arst_n,
    input  logic                 flush,
    fifo_rd_streamer_if.master   bus,
    output logic [15:0]          rd_count
);
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // The pop-credit arithmetic below assumes exactly two skid slots.
    if (SKID != 2) begin : g_bad_skid
        $error("fifo_rd_streamer: SKID must be 2");
    end

    logic [1:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    run_q, run_d;

    logic          m_valid;
    logic          fire;
    logic          capture;
    logic          pop;
    logic [2:0]    level;

    assign m_valid = (occ_q != OCC_EMPTY);
    assign fire    = m_valid & bus.m_ready;
    // A word returning during a flush cycle belongs to the dropped stream.
    assign capture = inflight_q & ~flush;
    // Occupancy the skid will have after this edge, counting the word in flight.
    assign level   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, fire};
    // run_q holds pops off for two edges after reset release.
    assign pop     = run_q[1] & ~bus.fifo_empty & ~flush & (level <= 3'd1);

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = m_valid;
    assign bus.m_data   = head_q;

    // Next-state logic for the skid: the head is always the oldest word, and the tail is the second word.
    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = pop;
        run_d      = {run_q[0], 1'b1};
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (capture) begin
                        head_d = bus.fifo_dout;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (capture && fire) begin
                        head_d = bus.fifo_dout;
                    end else if (capture) begin
                        tail_d = bus.fifo_dout;
                        occ_d  = OCC_TWO;
                    end else if (fire) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // Capture without fire cannot happen here because the pop rule forbids it.
                    if (fire) begin
                        head_d = tail_q;
                        if (capture) begin
                            tail_d = bus.fifo_dout;
                        end else begin
                            occ_d = OCC_ONE;
                        end
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end
    end

    // Skid, in-flight and reset-holdoff registers. Reset assertion clears them immediately.
    always_ff @(posedge rdclk or negedge arst_n) begin
        if (!arst_n) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            run_q      <= 2'b00;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            run_q      <= run_d;
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_count_q, rd_count_d;

    // Delivered-word count. It wraps at 16 bits, and flush does not affect it.
    always_comb begin
        rd_count_d = rd_count_q + {15'd0, fire};
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge rdclk or negedge arst_n) begin
        if (!arst_n) begin
            rd_count_q <= 16'h0000;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`else
    assign rd_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural FIFO model.
// The FIFO has a registered dout and is reset by arst_n.
`timescale 1ns/1ps
module tb_fifo_rd_streamer;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        flush;
    logic [15:0] rd_count;

    fifo_rd_streamer_if #(.DW(32)) bus();

    always #5 clk = ~clk;

    fifo_rd_streamer #(.DW(32), .SKID(2)) dut (
        .rdclk    (clk),
        .arst_n   (arst_n),
        .flush    (flush),
        .bus      (bus),
        .rd_count (rd_count)
    );

    // FIFO model: the initial block writes mem/wr_ptr, and the always block below owns rd_ptr/dout.
    logic [31:0] mem [0:255];
    int          wr_ptr;
    int          rd_ptr;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    // FIFO read port: data is registered, so it is valid the cycle after a pop. Reset discards the contents.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr        <= wr_ptr;
            bus.fifo_dout <= '0;
        end else if (bus.fifo_pop && (rd_ptr != wr_ptr)) begin
            bus.fifo_dout <= mem[rd_ptr % 256];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic        s_valid, s_pop, s_empty, s_ready;
    logic [31:0] s_data;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [31:0] prev_data = '0;
    logic        sb_on = 1'b0, hold_on = 1'b0, pe_on = 1'b0;
    int          fires = 0;
    int          fires_since_rst = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int since_rst);
`ifdef FIFO_RD_CNT_EN
        check(tag, 32'(rd_count), 32'(since_rst[15:0]));
`else
        check(tag, 32'(rd_count), 32'h0);
`endif
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    // Sample one cycle at the negedge. Score any fire, then advance to just after the next posedge.
    task automatic tick();
        logic [31:0] exp_w;
        @(negedge clk);
        s_valid = bus.m_valid;
        s_pop   = bus.fifo_pop;
        s_empty = bus.fifo_empty;
        s_data  = bus.m_data;
        s_ready = bus.m_ready;
        if (hold_on && prev_valid && !prev_ready) begin
            check("hold_valid", 32'(s_valid), 32'h1);
            check("hold_data", s_data, prev_data);
        end
        if (pe_on) check("pop_while_empty", 32'(s_pop & s_empty), 32'h0);
        if (s_valid && s_ready) begin
            fires++;
            fires_since_rst++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL sb_extra: observed word %h expected none", s_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (sb_on) check("sb_data", s_data, exp_w);
            end
        end
        prev_valid = s_valid;
        prev_ready = s_ready;
        prev_data  = s_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops;
        int cyc;
        int f0;
        int pushed;
        wr_ptr      = 0;
        flush       = 1'b0;
        bus.m_ready = 1'b0;
        arst_n      = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        tick();
        check("rst_m_valid", 32'(s_valid), 32'h0);
        check("rst_fifo_pop", 32'(s_pop), 32'h0);
        check("rst_m_data", s_data, 32'h0);
        check("rst_rd_count", 32'(rd_count), 32'h0);
        arst_n = 1'b1;
        sb_on  = 1'b1;
        repeat (3) tick();

        // ---- T2 streaming ----
        bus.m_ready = 1'b1;
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        tick();
        check("t2_first_pop", 32'(s_pop), 32'h1);
        check("t2_c0_valid", 32'(s_valid), 32'h0);
        tick();
        check("t2_c1_valid", 32'(s_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_stream_valid", 32'(s_valid), 32'h1);
            check("t2_stream_pop", 32'(s_pop), (i < 2) ? 32'h1 : 32'h0);
        end
        tick();
        check("t2_end_valid", 32'(s_valid), 32'h0);
        check("t2_drained", 32'(exp_q.size()), 32'h0);
        check_cnt("t2_rd_count", fires_since_rst);

        // ---- T3 backpressure ----
        bus.m_ready = 1'b0;
        hold_on = 1'b1;
        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
        pops = 0;
        repeat (10) begin
            tick();
            pops += int'(s_pop);
        end
        check("t3_pop_count", 32'(pops), 32'd2);
        check("t3_held_data", s_data, 32'hA0);
        check("t3_held_valid", 32'(s_valid), 32'h1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t3_no_gap", 32'(s_valid), 32'h1);
        end
        tick();
        check("t3_end_valid", 32'(s_valid), 32'h0);
        check("t3_drained", 32'(exp_q.size()), 32'h0);
        hold_on = 1'b0;

        // ---- T4 flush ----
        bus.m_ready = 1'b0;
        push(32'hB0);
        tick();
        tick();
        push(32'hB1);
        tick();
        check("t4_pop_before_flush", 32'(s_pop), 32'h1);
        check("t4_occ_one", 32'(s_valid), 32'h1);
        flush = 1'b1;
        tick();
        check("t4_flush_pop", 32'(s_pop), 32'h0);
        flush = 1'b0;
        exp_q.delete();
        push(32'hB2);
        tick();
        check("t4_valid_after_flush", 32'(s_valid), 32'h0);
        tick();
        check("t4_valid_refill", 32'(s_valid), 32'h0);
        bus.m_ready = 1'b1;
        tick();
        check("t4_next_word_valid", 32'(s_valid), 32'h1);
        check("t4_next_word", s_data, 32'hB2);
        tick();
        check("t4_end_valid", 32'(s_valid), 32'h0);
        check_cnt("t4_rd_count", fires_since_rst);

        // ---- T1 async reset mid-stream with a full skid ----
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(32'hC0 + 32'(i));
        repeat (3) tick();
        check("t1_pre_valid", 32'(s_valid), 32'h1);
        arst_n = 1'b0;
        #1;
        check("t1_async_valid", 32'(bus.m_valid), 32'h0);
        check("t1_async_pop", 32'(bus.fifo_pop), 32'h0);
        exp_q.delete();
        fires_since_rst = 0;
        tick();
        tick();
        check("t1_rd_count_clr", 32'(rd_count), 32'h0);
        arst_n = 1'b1;
        push(32'hD0);
        push(32'hD1);
        bus.m_ready = 1'b1;
        tick();
        check("t1_holdoff_e0", 32'(s_pop), 32'h0);
        tick();
        check("t1_holdoff_e1", 32'(s_pop), 32'h0);
        tick();
        check("t1_first_pop", 32'(s_pop), 32'h1);
        repeat (5) tick();
        check("t1_drained", 32'(exp_q.size()), 32'h0);
        check_cnt("t1_rd_count", fires_since_rst);

        // ---- T5 random ready, 1000 words ----
        hold_on = 1'b1;
        pe_on   = 1'b1;
        f0      = fires;
        pushed  = 0;
        cyc     = 0;
        while (((fires - f0) < 1000) && (cyc < 20000)) begin
            if ((pushed < 1000) && ((wr_ptr - rd_ptr) < 200) && ($urandom_range(0, 1) == 1)) begin
                push($urandom());
                pushed++;
            end
            bus.m_ready = ($urandom_range(0, 1) == 1);
            tick();
            cyc++;
        end
        check("t5_words_delivered", 32'(fires - f0), 32'd1000);
        check("t5_drained", 32'(exp_q.size()), 32'h0);
        check_cnt("t5_rd_count", fires_since_rst);
        hold_on = 1'b0;
        pe_on   = 1'b0;

`ifdef FIFO_RD_CNT_EN
        // ---- T6 counter wrap ----
        bus.m_ready = 1'b0;
        arst_n = 1'b0;
        #1;
        exp_q.delete();
        fires_since_rst = 0;
        tick();
        arst_n = 1'b1;
        repeat (2) tick();
        check("t6_cnt_clr", 32'(rd_count), 32'h0);
        bus.m_ready = 1'b1;
        pushed = 0;
        cyc    = 0;
        while (((pushed < 65534) || (exp_q.size() != 0)) && (cyc < 70000)) begin
            if ((pushed < 65534) && ((wr_ptr - rd_ptr) < 200)) begin
                push(32'(pushed));
                pushed++;
            end
            tick();
            cyc++;
        end
        check("t6_preload_drained", 32'(exp_q.size()), 32'h0);
        check("t6_cnt_fffe", 32'(rd_count), 32'h0000FFFE);
        push(32'hE0); push(32'hE1); push(32'hE2);
        repeat (8) tick();
        check("t6_cnt_wrap", 32'(rd_count), 32'h00000001);
`else
        check("t6_cnt_tied", 32'(rd_count), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
